// File: rtl/port_rx_sink.sv
// rtl/port_rx_sink.sv - receive sink for one switch output port with framing, length and destination checks
module port_rx_sink #(
  parameter int PORT_ID        = 0,
  parameter int data_width     = 64,
  parameter int priority_width = 3,
  parameter int len_width      = 10,
  parameter int hold_width     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_sop,
  input  logic                      rd_vld,
  input  logic [data_width-1:0]     rd_data,
  input  logic                      rd_eop,
  input  logic [hold_width-1:0]     hold_cycles,
  output logic                      ready,
  output logic                      pkt_done,
  output logic [priority_width-1:0] pkt_prio,
  output logic [len_width-1:0]      pkt_len,
  output logic [15:0]               pkt_cnt,
  output logic [31:0]               beat_cnt,
  output logic [7:0]                err_cnt,
  output logic [2:0]                err_code
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_GAP} state_t;

  localparam logic [3:0] PORT_ID_L = PORT_ID[3:0];

  state_t                    state_q, state_d;
  logic [len_width-1:0]      rem_q, rem_d;
  logic                      ovf_q, ovf_d;
  logic                      bad_q, bad_d;
  logic [priority_width-1:0] hprio_q, hprio_d;
  logic [len_width-1:0]      hlen_q, hlen_d;
  logic [hold_width-1:0]     gap_q, gap_d;

  logic                      ready_q;
  logic                      done_q;
  logic [priority_width-1:0] prio_q, prio_d;
  logic [len_width-1:0]      len_q, len_d;
  logic [15:0]               pkt_cnt_q, pkt_cnt_d;
  logic [31:0]               beat_cnt_q, beat_cnt_d;
  logic [7:0]                err_cnt_q, err_cnt_d;
  logic [2:0]                err_code_q, err_code_d;

  logic                      close;
  logic [7:1]                err_vec;
  logic [2:0]                err_num;
  logic [8:0]                err_sum;

  logic [3:0]                hdr_dest;
  logic [priority_width-1:0] hdr_prio;
  logic [len_width-1:0]      hdr_len;

  // Bits above the header fields are payload only; reduce them so every input bit has a reader.
  logic                      unused_data;
  assign unused_data = ^rd_data;

  assign hdr_dest = rd_data[3:0];
  assign hdr_prio = rd_data[4 +: priority_width];
  assign hdr_len  = rd_data[7 +: len_width];

  // Packet framing FSM: tracks header/body progress and raises one flag per error code.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    bad_d   = bad_q;
    hprio_d = hprio_q;
    hlen_d  = hlen_q;
    gap_d   = gap_q;
    close   = 1'b0;
    err_vec = '0;

    // A beat alongside a framing pulse is never part of the packet.
    if (rd_vld && (rd_sop || rd_eop)) err_vec[6] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rd_sop) begin
          state_d = S_HDR;
          rem_d   = '0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
          hprio_d = '0;
          hlen_d  = '0;
        end else begin
          if (rd_vld) err_vec[1] = 1'b1;
          if (rd_eop) err_vec[2] = 1'b1;
        end
      end
      S_HDR, S_BODY: begin
        if (rd_sop) begin
          // Abandon the partial packet silently and treat this sop as a fresh start.
          err_vec[7] = 1'b1;
          state_d    = S_HDR;
          rem_d      = '0;
          ovf_d      = 1'b0;
          bad_d      = 1'b0;
          hprio_d    = '0;
          hlen_d     = '0;
        end else if (state_q == S_HDR) begin
          if (rd_eop) begin
            err_vec[4] = 1'b1;
            close      = 1'b1;
            state_d    = S_GAP;
          end else if (rd_vld) begin
            hprio_d = hdr_prio;
            hlen_d  = hdr_len;
            rem_d   = hdr_len;
            state_d = S_BODY;
            if (hdr_dest != PORT_ID_L) begin
              err_vec[3] = 1'b1;
              bad_d      = 1'b1;
            end
          end
        end else begin
          if (rd_eop) begin
            close   = 1'b1;
            state_d = S_GAP;
            if ((rem_q != '0) || ovf_q) err_vec[5] = 1'b1;
          end else if (rd_vld) begin
            if (rem_q == '0) ovf_d = 1'b1;
            else             rem_d = rem_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (close) gap_d = hold_cycles;
  end

  // Status and counters: close snapshot, saturating error count, highest code wins per cycle.
  always_comb begin
    err_num    = '0;
    err_code_d = err_code_q;
    for (int k = 1; k <= 7; k++) begin
      if (err_vec[k]) begin
        err_num    = err_num + 3'd1;
        err_code_d = 3'(k);
      end
    end
    err_sum    = {1'b0, err_cnt_q} + {6'd0, err_num};
    err_cnt_d  = err_sum[8] ? 8'hFF : err_sum[7:0];
    beat_cnt_d = beat_cnt_q + {31'd0, rd_vld};
    pkt_cnt_d  = pkt_cnt_q;
    prio_d     = prio_q;
    len_d      = len_q;
    if (close) begin
      prio_d = hprio_q;
      len_d  = hlen_q;
      if (!bad_q && (err_vec == '0)) pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  // State and output registers; ready mirrors the next state so it lags the state change by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
      hprio_q    <= '0;
      hlen_q     <= '0;
      gap_q      <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      prio_q     <= '0;
      len_q      <= '0;
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      bad_q      <= bad_d;
      hprio_q    <= hprio_d;
      hlen_q     <= hlen_d;
      gap_q      <= gap_d;
      ready_q    <= (state_d == S_IDLE);
      done_q     <= close;
      prio_q     <= prio_d;
      len_q      <= len_d;
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  assign ready    = ready_q;
  assign pkt_done = done_q;
  assign pkt_prio = prio_q;
  assign pkt_len  = len_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_port_rx_sink.sv
// tb/tb_port_rx_sink.sv - randomized scoreboard bench for port_rx_sink
module tb_port_rx_sink;

  localparam int PID = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_sop = 1'b0;
  logic        rd_vld = 1'b0;
  logic [63:0] rd_data = '0;
  logic        rd_eop = 1'b0;
  logic [3:0]  hold_cycles = '0;
  logic        ready;
  logic        pkt_done;
  logic [2:0]  pkt_prio;
  logic [9:0]  pkt_len;
  logic [15:0] pkt_cnt;
  logic [31:0] beat_cnt;
  logic [7:0]  err_cnt;
  logic [2:0]  err_code;

  port_rx_sink #(
    .PORT_ID(PID), .data_width(64), .priority_width(3), .len_width(10), .hold_width(4)
  ) dut (
    .clk(clk), .rst(rst), .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_data(rd_data),
    .rd_eop(rd_eop), .hold_cycles(hold_cycles), .ready(ready), .pkt_done(pkt_done),
    .pkt_prio(pkt_prio), .pkt_len(pkt_len), .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt),
    .err_cnt(err_cnt), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  prio;
    logic [9:0]  len;
    bit          chk_hdr;
    logic [15:0] pkt;
    logic [31:0] beat;
    logic [7:0]  err;
    logic [2:0]  code;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_pkt  = '0;
  logic [31:0] m_beat = '0;
  logic [7:0]  m_err  = '0;
  logic [2:0]  m_code = '0;
  bit          m_bad  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && pkt_done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pkt_done_unexpected: got pulse expected none at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_hdr) begin
          chk("pkt_prio", 32'(pkt_prio), 32'(mon_e.prio));
          chk("pkt_len", 32'(pkt_len), 32'(mon_e.len));
        end
        chk("pkt_cnt", 32'(pkt_cnt), 32'(mon_e.pkt));
        chk("beat_cnt", beat_cnt, mon_e.beat);
        chk("err_cnt", 32'(err_cnt), 32'(mon_e.err));
        chk("err_code", 32'(err_code), 32'(mon_e.code));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic m_error(input int code);
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    m_code = code[2:0];
    m_bad  = 1'b1;
  endtask

  task automatic push_close(input int prio, input int len, input bit hdr_valid);
    exp_t e;
    if (!m_bad) m_pkt = m_pkt + 16'd1;
    e.prio = prio[2:0];
    e.len = len[9:0];
    e.chk_hdr = hdr_valid;
    e.pkt = m_pkt;
    e.beat = m_beat;
    e.err = m_err;
    e.code = m_code;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic s, input logic v, input logic e, input logic [63:0] d);
    rd_sop = s; rd_vld = v; rd_eop = e; rd_data = d;
    @(posedge clk);
    #1;
    rd_sop = 1'b0; rd_vld = 1'b0; rd_eop = 1'b0; rd_data = {$urandom, $urandom};
    if (v) m_beat = m_beat + 32'd1;
  endtask

  task automatic rgap();
    repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  function automatic logic [63:0] mk_hdr(input int dest, input int prio, input int n);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[3:0] = dest[3:0];
    d[6:4] = prio[2:0];
    d[16:7] = n[9:0];
    return d;
  endfunction

  // Called right after the eop cycle: ready stays low h more cycles, then rises.
  task automatic check_gap(input int h);
    chk("ready_at_eop", 32'(ready), 32'd0);
    for (int i = 0; i < h; i++) begin
      @(posedge clk); #1;
      chk("ready_gap_low", 32'(ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("ready_after_gap", 32'(ready), 32'd1);
  endtask

  task automatic send_sop();
    chk("ready_idle", 32'(ready), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    chk("ready_fall", 32'(ready), 32'd0);
  endtask

  task automatic send_pkt(input int dest, input int prio, input int n, input int nbody,
                          input int hold, input bit with_sop);
    hold_cycles = hold[3:0];
    m_bad = 1'b0;
    if (with_sop) send_sop();
    rgap();
    if (dest != PID) m_error(3);
    cyc(1'b0, 1'b1, 1'b0, mk_hdr(dest, prio, n));
    for (int i = 0; i < nbody; i++) begin
      if (n < 64) rgap();
      cyc(1'b0, 1'b1, 1'b0, {$urandom, $urandom});
    end
    rgap();
    if (nbody != n) m_error(5);
    push_close(prio, n, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    check_gap(hold);
  endtask

  task automatic empty_pkt(input int hold);
    hold_cycles = hold[3:0];
    m_bad = 1'b0;
    send_sop();
    rgap();
    m_error(4);
    push_close(0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    check_gap(hold);
  endtask

  task automatic stray_vld();
    m_error(1);
    cyc(1'b0, 1'b1, 1'b0, {$urandom, $urandom});
    chk("stray_vld_err_cnt", 32'(err_cnt), 32'(m_err));
    chk("stray_vld_err_code", 32'(err_code), 32'(m_code));
    chk("stray_vld_beat_cnt", beat_cnt, m_beat);
  endtask

  task automatic stray_eop();
    m_error(2);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("stray_eop_err_cnt", 32'(err_cnt), 32'(m_err));
    chk("stray_eop_err_code", 32'(err_code), 32'(m_code));
  endtask

  // Starts a packet, sends part of its body, then a new sop restarts; the follow-up packet has no own sop.
  task automatic abort_then_pkt(input int prio, input int n, input int hold);
    int n0;
    int k;
    n0 = $urandom_range(2, 8);
    k = $urandom_range(0, n0 - 1);
    m_bad = 1'b0;
    send_sop();
    cyc(1'b0, 1'b1, 1'b0, mk_hdr(PID, $urandom_range(0, 7), n0));
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b1, 1'b0, {$urandom, $urandom});
    m_error(7);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    chk("abort_err_code", 32'(err_code), 32'd7);
    chk("abort_ready", 32'(ready), 32'd0);
    send_pkt(PID, prio, n, n, hold, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
    chk({tag, "_pkt_prio"}, 32'(pkt_prio), 32'd0);
    chk({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
    chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    chk({tag, "_beat_cnt"}, beat_cnt, 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(ready), 32'd1);

    send_pkt(PID, 3, 3, 3, 0, 1'b1);
    send_pkt(PID, 1, 4, 2, 0, 1'b1);
    send_pkt(9, 6, 5, 5, 0, 1'b1);
    stray_vld();
    stray_eop();
    abort_then_pkt(2, 3, 0);
    send_pkt(PID, 4, 2, 2, 4, 1'b1);
    send_pkt(PID, 5, 1, 1, 4, 1'b1);
    send_pkt(PID, 0, 0, 0, 0, 1'b1);
    send_pkt(PID, 7, 0, 1, 1, 1'b1);
    empty_pkt(2);

    for (int t = 0; t < 40; t++) begin
      int kind;
      int n;
      int hold;
      int nb;
      kind = $urandom_range(0, 9);
      n = $urandom_range(0, 20);
      hold = $urandom_range(0, 3);
      case (kind)
        5: send_pkt($urandom_range(0, 15), $urandom_range(0, 7), n, n, hold, 1'b1);
        6: begin
          nb = ($urandom_range(0, 1) == 0) ? n + $urandom_range(1, 2)
                                            : ((n > 2) ? n - $urandom_range(1, 2) : n + 1);
          send_pkt(PID, $urandom_range(0, 7), n, nb, hold, 1'b1);
        end
        7: empty_pkt(hold);
        8: if ($urandom_range(0, 1) == 0) stray_vld(); else stray_eop();
        9: abort_then_pkt($urandom_range(0, 7), n, hold);
        default: send_pkt(PID, $urandom_range(0, 7), n, n, hold, 1'b1);
      endcase
    end

    send_pkt(PID, 7, 1023, 1023, 1, 1'b1);

    // Reset in the middle of a body, then a header-only packet.
    hold_cycles = 4'd0;
    send_sop();
    cyc(1'b0, 1'b1, 1'b0, mk_hdr(PID, 2, 5));
    cyc(1'b0, 1'b1, 1'b0, 64'd1);
    cyc(1'b0, 1'b1, 1'b0, 64'd2);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("midrst_hold");
    chk("midrst_queue_empty", 32'(sb.size()), 32'd0);
    m_pkt = '0; m_beat = '0; m_err = '0; m_code = '0; m_bad = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_midrst", 32'(ready), 32'd1);
    send_pkt(PID, 6, 0, 0, 0, 1'b1);
    chk("post_rst_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("post_rst_beat_cnt", beat_cnt, 32'd1);

    repeat (260) stray_vld();
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
    send_pkt(PID, 1, 2, 2, 0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("final_pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
    chk("final_beat_cnt", beat_cnt, m_beat);
    chk("final_err_cnt", 32'(err_cnt), 32'(m_err));
    chk("final_err_code", 32'(err_code), 32'(m_code));
    chk("final_ready", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/port_rx_sink.md
# port_rx_sink

Synthesizable receive sink for one switch output port. Consumes the `rd_sop`/`rd_vld`/`rd_data`/`rd_eop` stream the switch emits for its port, drives that port's `ready`, and checks framing, destination and length against the packet header. Exposes packet, beat and error counters. Sixteen instances, one per `rd_*` lane, form the output side of the switch test harness and FPGA demo.

## Interface
- `PORT_ID`, 0: this sink's port number; compared with the header destination field.
- `data_width`, 64: `rd_data` width.
- `priority_width`, 3: header priority field width.
- `len_width`, 10: header payload-length field width, counted in beats.
- `hold_width`, 4: width of `hold_cycles`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_sop`  in  1  start-of-packet pulse.
- `rd_vld`  in  1  data beat valid.
- `rd_data`  in  data_width  data beat.
- `rd_eop`  in  1  end-of-packet pulse.
- `hold_cycles`  in  hold_width  `ready`-low gap inserted after each packet.
- `ready`  out  1  port can accept a new packet.
- `pkt_done`  out  1  one-cycle pulse when a packet closes, good or bad.
- `pkt_prio`  out  priority_width  priority of the last closed packet.
- `pkt_len`  out  len_width  header length of the last closed packet.
- `pkt_cnt`  out  16  number of good packets.
- `beat_cnt`  out  32  total accepted `rd_vld` beats.
- `err_cnt`  out  8  number of errors; saturates at 255.
- `err_code`  out  3  code of the most recent error; 0 means none.

## Operation
- Header is the first `rd_vld` beat after `rd_sop`:
  - `[3:0]` destination port.
  - `[4+priority_width-1:4]` priority.
  - `[7+len_width-1:7]` payload beat count N, excluding the header beat.
  - Total beats per packet = N+1.
- Protocol:
  - `rd_sop` precedes the header beat by one or more cycles.
  - `rd_vld` beats may have gaps.
  - `rd_eop` comes one or more cycles after the last `rd_vld`.
  - `rd_vld` coincident with `rd_sop` or `rd_eop` is a protocol error (code 6). That beat is counted in `beat_cnt` but not in the packet.
- FSM states and transitions:
  - IDLE:
    - `rd_sop` -> HDR.
    - `rd_vld` -> stay, err 1 (stray beat).
    - `rd_eop` -> stay, err 2 (stray eop).
  - HDR:
    - `rd_vld` -> latch header. If dest != `PORT_ID`, flag err 3 (still received to eop). Set `rem` = N, go to BODY.
    - `rd_eop` -> err 4 (empty packet), close, go to GAP.
  - BODY:
    - `rd_vld` decrements `rem`.
    - `rd_eop` -> close. If `rem` != 0, err 5 (length mismatch). Go to GAP.
    - A `rd_vld` with `rem` == 0 sets an overflow flag, reported as err 5 at eop.
  - Any state except IDLE/GAP: `rd_sop` -> err 7 (sop inside packet). Abandon the current packet without `pkt_done`, restart in HDR.
  - GAP: hold `ready` low for `hold_cycles` cycles, then go to IDLE. With `hold_cycles` = 0, go straight to IDLE next cycle.
- Close:
  - `pkt_done` pulses.
  - `pkt_prio` and `pkt_len` update.
  - `pkt_cnt` increments only if no error was flagged for this packet.
- One packet may report several errors. `err_cnt` counts each. `err_code` shows the last one, with the higher code winning within a single cycle.
- `ready` = 1 only in IDLE. It is registered: it changes the cycle after the state change.

## Timing
- Reset values: `ready`=0, `pkt_done`=0, `pkt_prio`=0, `pkt_len`=0, all counters 0, `err_code`=0, state IDLE. `ready` rises on the first clock edge after `rst` falls.
- `rst` asserted mid-packet: everything clears immediately, the partial packet is dropped with no `pkt_done`.
- `pkt_done`, `pkt_*` and counter updates occur on the clock edge that samples `rd_eop` (1-cycle latency, visible the next cycle).
- `ready` falls the cycle after `rd_sop` is sampled.
- `ready` rises `hold_cycles`+1 cycles after the cycle where `rd_eop` is sampled.
- Counter widths:
  - `beat_cnt` wraps modulo 2^32.
  - `pkt_cnt` wraps modulo 2^16.
  - `err_cnt` saturates at 255.
- N = 0 is legal: a header-only packet (1 beat).
- N = 2^len_width−1 is the maximum; `rem` must hold it.

## Test plan
- PORT_ID=5, `hold_cycles`=0:
  - Stimulus: sop, header (dest 5, prio 3, N=3), 3 beats, eop.
  - Response: `pkt_done` once, `pkt_cnt`=1, `beat_cnt`=4, `pkt_prio`=3, `pkt_len`=3, `err_code`=0.
  - `ready` low from the cycle after sop until the cycle after eop.
- Header with N=4 but only 2 body beats before eop:
  - Response: err 5, `err_cnt`=1, `pkt_cnt`=0, `pkt_done` pulses.
- Header with dest 9 to PORT_ID=5, lengths correct:
  - Response: err 3, `pkt_cnt` unchanged, `beat_cnt` still advances by N+1.
- Stray `rd_vld`, then stray `rd_eop` in IDLE, then sop inside BODY followed by a clean packet:
  - Response: `err_cnt`=3, `err_code`=7, `pkt_cnt`=1, a single `pkt_done`.
- `hold_cycles`=4, two back-to-back packets:
  - Response: `ready` stays low for exactly 4 cycles after the eop edge cycle, then high.
  - Second packet accepted with `pkt_cnt`=2.
- Assert `rst` mid-BODY, release, send one clean N=0 packet:
  - Response: all counters 0 during reset, `ready` 0 in reset and 1 one cycle after release.
  - Then `pkt_cnt`=1, `beat_cnt`=1.
